// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one 32-bit MAC TX frame interface
// between up to four requesters, with grant timeout and frame-length guard.
module eth_tx_frame_arbiter #(
   parameter int PORTS         = 2,
   parameter int GRANT_TIMEOUT = 16,
   parameter int MAX_WORDS     = 384
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [PORTS-1:0]     req,
   output logic [PORTS-1:0]     grant,
   input  logic [PORTS-1:0]     in_frame_start,
   input  logic [PORTS-1:0]     in_frame_data_valid,
   input  logic [3*PORTS-1:0]   in_frame_bytes_valid,
   input  logic [32*PORTS-1:0]  in_frame_data,
   input  logic [PORTS-1:0]     in_frame_commit,
   input  logic [PORTS-1:0]     in_frame_drop,
   output logic                 out_frame_start,
   output logic                 out_frame_data_valid,
   output logic [2:0]           out_frame_bytes_valid,
   output logic [31:0]          out_frame_data,
   output logic                 out_frame_commit,
   output logic                 out_frame_drop,
   output logic [1:0]           active_port,
   output logic                 err_timeout,
   output logic                 err_overflow,
   output logic [2:0]           dbg_state
);

   localparam int TW = $clog2(GRANT_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_FRAME = 3'd2;
   localparam logic [2:0] S_TRUNC = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [8:0]    MAX_W    = 9'(MAX_WORDS);
   localparam logic [TW-1:0] TO_LIMIT = TW'(GRANT_TIMEOUT);

   logic [2:0]       state_q, state_d;
   logic [1:0]       last_q, last_d;
   logic [1:0]       active_port_q, active_port_d;
   logic [PORTS-1:0] grant_q, grant_d;
   logic [TW-1:0]    tcnt_q, tcnt_d, tcnt_inc;
   logic [8:0]       wcnt_q, wcnt_d;
   logic             out_start_q, out_start_d;
   logic             out_dv_q, out_dv_d;
   logic [2:0]       out_bv_q, out_bv_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             out_commit_q, out_commit_d;
   logic             out_drop_q, out_drop_d;
   logic             err_timeout_q, err_timeout_d;
   logic             err_overflow_q, err_overflow_d;

   logic             sel_start, sel_dv, sel_commit, sel_drop;
   logic [2:0]       sel_bv;
   logic [31:0]      sel_data;
   logic             rr_found;
   logic [1:0]       rr_pick;
   int               rr_dist, rr_best;
   logic             ovf_word;

   // Only the currently granted port's inputs are ever looked at.
   always_comb begin
      sel_start  = 1'b0;
      sel_dv     = 1'b0;
      sel_commit = 1'b0;
      sel_drop   = 1'b0;
      sel_bv     = 3'd0;
      sel_data   = 32'd0;
      for (int i = 0; i < PORTS; i++) begin
         if (active_port_q == 2'(i)) begin
            sel_start  = in_frame_start[i];
            sel_dv     = in_frame_data_valid[i];
            sel_commit = in_frame_commit[i];
            sel_drop   = in_frame_drop[i];
            sel_bv     = in_frame_bytes_valid[3*i +: 3];
            sel_data   = in_frame_data[32*i +: 32];
         end
      end
   end

   // Round robin: the requester closest after last_q (modulo PORTS) wins.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = last_q;
      rr_best  = PORTS;
      rr_dist  = 0;
      for (int j = 0; j < PORTS; j++) begin
         rr_dist = (j + 2 * PORTS - int'(last_q) - 1) % PORTS;
         if (req[j] && (rr_dist < rr_best)) begin
            rr_best  = rr_dist;
            rr_pick  = 2'(j);
            rr_found = 1'b1;
         end
      end
   end

   assign tcnt_inc = tcnt_q + TW'(1);
   assign ovf_word = sel_dv && (wcnt_q == MAX_W);

   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      active_port_d  = active_port_q;
      grant_d        = grant_q;
      tcnt_d         = tcnt_q;
      wcnt_d         = wcnt_q;
      out_start_d    = 1'b0;
      out_dv_d       = 1'b0;
      out_bv_d       = 3'd0;
      out_data_d     = 32'd0;
      out_commit_d   = 1'b0;
      out_drop_d     = 1'b0;
      err_timeout_d  = 1'b0;
      err_overflow_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               for (int i = 0; i < PORTS; i++) grant_d[i] = (rr_pick == 2'(i));
               last_d        = rr_pick;
               active_port_d = rr_pick;
               tcnt_d        = '0;
               state_d       = S_GRANT;
            end
         end
         S_GRANT: begin
            if (sel_start) begin
               out_start_d = 1'b1;
               wcnt_d      = 9'd0;
               state_d     = S_FRAME;
            end else if (tcnt_inc == TO_LIMIT) begin
               err_timeout_d = 1'b1;
               grant_d       = '0;
               state_d       = S_GAP;
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         S_FRAME: begin
            if (sel_start) begin
               out_drop_d = 1'b1;
               grant_d    = '0;
               state_d    = S_GAP;
            end else begin
               if (ovf_word) begin
                  out_drop_d     = 1'b1;
                  err_overflow_d = 1'b1;
                  state_d        = S_TRUNC;
               end else if (sel_dv) begin
                  out_dv_d   = 1'b1;
                  out_bv_d   = sel_bv;
                  out_data_d = sel_data;
                  wcnt_d     = wcnt_q + 9'd1;
               end
               // An end event alongside the overflow word closes the frame; the drop is already out.
               if (sel_drop || sel_commit) begin
                  grant_d = '0;
                  state_d = S_GAP;
                  if (!ovf_word) begin
                     out_drop_d   = sel_drop;
                     out_commit_d = !sel_drop;
                  end
               end
            end
         end
         S_TRUNC: begin
            if (sel_drop || sel_commit) begin
               grant_d = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= S_IDLE;
         last_q         <= 2'(PORTS - 1);
         active_port_q  <= 2'd0;
         grant_q        <= '0;
         tcnt_q         <= '0;
         wcnt_q         <= 9'd0;
         out_start_q    <= 1'b0;
         out_dv_q       <= 1'b0;
         out_bv_q       <= 3'd0;
         out_data_q     <= 32'd0;
         out_commit_q   <= 1'b0;
         out_drop_q     <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_q         <= last_d;
         active_port_q  <= active_port_d;
         grant_q        <= grant_d;
         tcnt_q         <= tcnt_d;
         wcnt_q         <= wcnt_d;
         out_start_q    <= out_start_d;
         out_dv_q       <= out_dv_d;
         out_bv_q       <= out_bv_d;
         out_data_q     <= out_data_d;
         out_commit_q   <= out_commit_d;
         out_drop_q     <= out_drop_d;
         err_timeout_q  <= err_timeout_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   assign grant                 = grant_q;
   assign active_port           = active_port_q;
   assign out_frame_start       = out_start_q;
   assign out_frame_data_valid  = out_dv_q;
   assign out_frame_bytes_valid = out_bv_q;
   assign out_frame_data        = out_data_q;
   assign out_frame_commit      = out_commit_q;
   assign out_frame_drop        = out_drop_q;
   assign err_timeout           = err_timeout_q;
   assign err_overflow          = err_overflow_q;
   assign dbg_state             = state_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: four ports, 16-cycle grant timeout,
// four-word frame limit so the overflow path is reachable quickly.
module tb_eth_tx_frame_arbiter;

   localparam int PORTS = 4;

   logic                sys_clk = 1'b0;
   logic                sys_rst_n;
   logic [PORTS-1:0]    req;
   logic [PORTS-1:0]    grant;
   logic [PORTS-1:0]    in_frame_start;
   logic [PORTS-1:0]    in_frame_data_valid;
   logic [3*PORTS-1:0]  in_frame_bytes_valid;
   logic [32*PORTS-1:0] in_frame_data;
   logic [PORTS-1:0]    in_frame_commit;
   logic [PORTS-1:0]    in_frame_drop;
   logic                out_frame_start;
   logic                out_frame_data_valid;
   logic [2:0]          out_frame_bytes_valid;
   logic [31:0]         out_frame_data;
   logic                out_frame_commit;
   logic                out_frame_drop;
   logic [1:0]          active_port;
   logic                err_timeout;
   logic                err_overflow;
   logic [2:0]          dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // {start, data_valid, bytes_valid, data, commit, drop}
   logic [38:0] out_bus;
   assign out_bus = {out_frame_start, out_frame_data_valid, out_frame_bytes_valid,
                     out_frame_data, out_frame_commit, out_frame_drop};

   eth_tx_frame_arbiter #(
      .PORTS(PORTS),
      .GRANT_TIMEOUT(16),
      .MAX_WORDS(4)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .req(req),
      .grant(grant),
      .in_frame_start(in_frame_start),
      .in_frame_data_valid(in_frame_data_valid),
      .in_frame_bytes_valid(in_frame_bytes_valid),
      .in_frame_data(in_frame_data),
      .in_frame_commit(in_frame_commit),
      .in_frame_drop(in_frame_drop),
      .out_frame_start(out_frame_start),
      .out_frame_data_valid(out_frame_data_valid),
      .out_frame_bytes_valid(out_frame_bytes_valid),
      .out_frame_data(out_frame_data),
      .out_frame_commit(out_frame_commit),
      .out_frame_drop(out_frame_drop),
      .active_port(active_port),
      .err_timeout(err_timeout),
      .err_overflow(err_overflow),
      .dbg_state(dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_in();
      in_frame_start       = '0;
      in_frame_data_valid  = '0;
      in_frame_bytes_valid = '0;
      in_frame_data        = '0;
      in_frame_commit      = '0;
      in_frame_drop        = '0;
   endtask

   task automatic drive_word(input int p, input logic [31:0] d, input logic [2:0] bv);
      in_frame_data_valid[p]        = 1'b1;
      in_frame_bytes_valid[3*p +: 3] = bv;
      in_frame_data[32*p +: 32]      = d;
   endtask

   function automatic logic [38:0] exp_word(input logic [31:0] d, input logic [2:0] bv,
                                            input logic commit, input logic drop);
      return {1'b0, 1'b1, bv, d, commit, drop};
   endfunction

   function automatic logic [38:0] exp_ctrl(input logic start, input logic commit, input logic drop);
      return {start, 1'b0, 3'd0, 32'd0, commit, drop};
   endfunction

   task automatic test_reset();
      sys_rst_n = 1'b0;
      req = '0;
      clear_in();
      repeat (2) step();
      n_checks++;
      if ({out_bus, grant, active_port, err_timeout, err_overflow} !== '0)
         $display("FAIL reset_outputs got=%h exp=0", {out_bus, grant, active_port, err_timeout, err_overflow});
      else n_pass++;
      n_checks++;
      if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state);
      else n_pass++;
      #2 sys_rst_n = 1'b1;
      step();
      n_checks++;
      if (grant !== 4'b0000) $display("FAIL reset_no_req_grant got=%b exp=0000", grant);
      else n_pass++;
   endtask

   task automatic test_single();
      req = 4'b0001;
      step();
      n_checks++;
      if ({grant, active_port} !== {4'b0001, 2'd0})
         $display("FAIL single_grant got=%b/%0d exp=0001/0", grant, active_port);
      else n_pass++;
      in_frame_start[0] = 1'b1;
      step();
      n_checks++;
      if (out_bus !== exp_ctrl(1'b1, 1'b0, 1'b0)) $display("FAIL single_start got=%h exp=%h", out_bus, exp_ctrl(1'b1, 1'b0, 1'b0));
      else n_pass++;
      clear_in();
      req = 4'b0000;
      drive_word(0, 32'h11111111, 3'd4);
      step();
      n_checks++;
      if (out_bus !== exp_word(32'h11111111, 3'd4, 1'b0, 1'b0)) $display("FAIL single_w1 got=%h exp=%h", out_bus, exp_word(32'h11111111, 3'd4, 1'b0, 1'b0));
      else n_pass++;
      n_checks++;
      if (grant !== 4'b0001) $display("FAIL single_grant_held got=%b exp=0001", grant);
      else n_pass++;
      clear_in();
      drive_word(0, 32'h22222222, 3'd4);
      step();
      n_checks++;
      if (out_bus !== exp_word(32'h22222222, 3'd4, 1'b0, 1'b0)) $display("FAIL single_w2 got=%h exp=%h", out_bus, exp_word(32'h22222222, 3'd4, 1'b0, 1'b0));
      else n_pass++;
      clear_in();
      drive_word(0, 32'h33333333, 3'd2);
      step();
      n_checks++;
      if (out_bus !== exp_word(32'h33333333, 3'd2, 1'b0, 1'b0)) $display("FAIL single_w3 got=%h exp=%h", out_bus, exp_word(32'h33333333, 3'd2, 1'b0, 1'b0));
      else n_pass++;
      clear_in();
      in_frame_commit[0] = 1'b1;
      step();
      n_checks++;
      if ({out_bus, grant} !== {exp_ctrl(1'b0, 1'b1, 1'b0), 4'b0000})
         $display("FAIL single_commit got=%h/%b exp=%h/0000", out_bus, grant, exp_ctrl(1'b0, 1'b1, 1'b0));
      else n_pass++;
      clear_in();
      step();
      n_checks++;
      if ({out_bus, grant} !== '0) $display("FAIL single_gap got=%h/%b exp=0/0000", out_bus, grant);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int p;
      clear_in();
      req = '0;
      sys_rst_n = 1'b0;
      step();
      sys_rst_n = 1'b1;
      step();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         p = k % PORTS;
         step();
         n_checks++;
         if ({grant, active_port} !== {4'(1 << p), 2'(p)})
            $display("FAIL rr_grant_%0d got=%b/%0d exp=%b/%0d", k, grant, active_port, 4'(1 << p), p);
         else n_pass++;
         clear_in();
         in_frame_start[p] = 1'b1;
         in_frame_commit[(p + 1) % PORTS] = 1'b1;
         step();
         n_checks++;
         if (out_bus !== exp_ctrl(1'b1, 1'b0, 1'b0)) $display("FAIL rr_start_%0d got=%h exp=%h", k, out_bus, exp_ctrl(1'b1, 1'b0, 1'b0));
         else n_pass++;
         clear_in();
         drive_word(p, 32'hA0000000 | 32'(k), 3'd4);
         drive_word((p + 2) % PORTS, 32'hBAD0BAD0, 3'd1);
         step();
         n_checks++;
         if (out_bus !== exp_word(32'hA0000000 | 32'(k), 3'd4, 1'b0, 1'b0))
            $display("FAIL rr_data_%0d got=%h exp=%h", k, out_bus, exp_word(32'hA0000000 | 32'(k), 3'd4, 1'b0, 1'b0));
         else n_pass++;
         clear_in();
         in_frame_commit[p] = 1'b1;
         step();
         n_checks++;
         if (out_bus !== exp_ctrl(1'b0, 1'b1, 1'b0)) $display("FAIL rr_commit_%0d got=%h exp=%h", k, out_bus, exp_ctrl(1'b0, 1'b1, 1'b0));
         else n_pass++;
         clear_in();
         step();
      end
      n_checks++;
      if ({grant, active_port} !== {4'b0000, 2'd0}) $display("FAIL rr_idle_hold got=%b/%0d exp=0000/0", grant, active_port);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int bad;
      clear_in();
      req = 4'b0010;
      step();
      n_checks++;
      if ({grant, active_port} !== {4'b0010, 2'd1}) $display("FAIL to_grant got=%b/%0d exp=0010/1", grant, active_port);
      else n_pass++;
      req = 4'b0011;
      in_frame_start[0] = 1'b1;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (grant !== 4'b0010 || err_timeout !== 1'b0 || out_bus !== '0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL to_wait_cycles got=%0d bad cycles exp=0", bad);
      else n_pass++;
      step();
      n_checks++;
      if ({err_timeout, grant, out_bus} !== {1'b1, 4'b0000, 39'd0})
         $display("FAIL to_fire got=%b/%b/%h exp=1/0000/0", err_timeout, grant, out_bus);
      else n_pass++;
      clear_in();
      step();
      n_checks++;
      if ({err_timeout, grant} !== 5'b0) $display("FAIL to_pulse_len got=%b/%b exp=0/0000", err_timeout, grant);
      else n_pass++;
      step();
      n_checks++;
      if ({grant, active_port} !== {4'b0001, 2'd0}) $display("FAIL to_next_grant got=%b/%0d exp=0001/0", grant, active_port);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      req = 4'b0000;
      clear_in();
      in_frame_start[0] = 1'b1;
      step();
      n_checks++;
      if (out_bus !== exp_ctrl(1'b1, 1'b0, 1'b0)) $display("FAIL ovf_start got=%h exp=%h", out_bus, exp_ctrl(1'b1, 1'b0, 1'b0));
      else n_pass++;
      for (int w = 1; w <= 6; w++) begin
         clear_in();
         d = 32'h01010101 * 32'(w);
         drive_word(0, d, 3'd4);
         step();
         n_checks++;
         if (w <= 4) begin
            if ({out_bus, err_overflow} !== {exp_word(d, 3'd4, 1'b0, 1'b0), 1'b0})
               $display("FAIL ovf_word_%0d got=%h/%b exp=%h/0", w, out_bus, err_overflow, exp_word(d, 3'd4, 1'b0, 1'b0));
            else n_pass++;
         end else if (w == 5) begin
            if ({out_bus, err_overflow} !== {exp_ctrl(1'b0, 1'b0, 1'b1), 1'b1})
               $display("FAIL ovf_drop got=%h/%b exp=%h/1", out_bus, err_overflow, exp_ctrl(1'b0, 1'b0, 1'b1));
            else n_pass++;
         end else begin
            if ({out_bus, err_overflow} !== 40'd0) $display("FAIL ovf_trunc_quiet got=%h/%b exp=0/0", out_bus, err_overflow);
            else n_pass++;
         end
      end
      clear_in();
      in_frame_commit[0] = 1'b1;
      step();
      n_checks++;
      if ({out_bus, grant} !== '0) $display("FAIL ovf_no_commit got=%h/%b exp=0/0000", out_bus, grant);
      else n_pass++;
      clear_in();
      step();
   endtask

   task automatic test_simultaneous_end();
      req = 4'b0100;
      step();
      n_checks++;
      if ({grant, active_port} !== {4'b0100, 2'd2}) $display("FAIL sim_grant got=%b/%0d exp=0100/2", grant, active_port);
      else n_pass++;
      req = 4'b0000;
      clear_in();
      in_frame_start[2] = 1'b1;
      step();
      clear_in();
      drive_word(2, 32'hDEADBEEF, 3'd3);
      in_frame_commit[2] = 1'b1;
      in_frame_drop[2]   = 1'b1;
      step();
      n_checks++;
      if ({out_bus, grant} !== {exp_word(32'hDEADBEEF, 3'd3, 1'b0, 1'b1), 4'b0000})
         $display("FAIL sim_end got=%h/%b exp=%h/0000", out_bus, grant, exp_word(32'hDEADBEEF, 3'd3, 1'b0, 1'b1));
      else n_pass++;
      clear_in();
      step();
   endtask

   task automatic test_restart();
      req = 4'b1000;
      step();
      n_checks++;
      if ({grant, active_port} !== {4'b1000, 2'd3}) $display("FAIL rs_grant got=%b/%0d exp=1000/3", grant, active_port);
      else n_pass++;
      req = 4'b0000;
      clear_in();
      in_frame_start[3] = 1'b1;
      step();
      clear_in();
      drive_word(3, 32'h5A5A0003, 3'd1);
      step();
      n_checks++;
      if (out_bus !== exp_word(32'h5A5A0003, 3'd1, 1'b0, 1'b0)) $display("FAIL rs_word got=%h exp=%h", out_bus, exp_word(32'h5A5A0003, 3'd1, 1'b0, 1'b0));
      else n_pass++;
      clear_in();
      in_frame_start[3] = 1'b1;
      step();
      n_checks++;
      if ({out_bus, grant} !== {exp_ctrl(1'b0, 1'b0, 1'b1), 4'b0000})
         $display("FAIL rs_drop got=%h/%b exp=%h/0000", out_bus, grant, exp_ctrl(1'b0, 1'b0, 1'b1));
      else n_pass++;
      clear_in();
      step();
   endtask

   task automatic test_reset_mid_frame();
      req = 4'b0010;
      step();
      req = 4'b0000;
      clear_in();
      in_frame_start[1] = 1'b1;
      step();
      clear_in();
      drive_word(1, 32'hCAFEF00D, 3'd4);
      step();
      n_checks++;
      if (out_bus !== exp_word(32'hCAFEF00D, 3'd4, 1'b0, 1'b0)) $display("FAIL rm_word got=%h exp=%h", out_bus, exp_word(32'hCAFEF00D, 3'd4, 1'b0, 1'b0));
      else n_pass++;
      #2 sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_bus, grant, active_port, err_timeout, err_overflow} !== '0)
         $display("FAIL rm_async_clear got=%h exp=0", {out_bus, grant, active_port, err_timeout, err_overflow});
      else n_pass++;
      clear_in();
      req = 4'b0011;
      #3 sys_rst_n = 1'b1;
      step();
      n_checks++;
      if ({grant, active_port} !== {4'b0001, 2'd0}) $display("FAIL rm_priority got=%b/%0d exp=0001/0", grant, active_port);
      else n_pass++;
      n_checks++;
      if (out_bus !== '0) $display("FAIL rm_no_end_event got=%h exp=0", out_bus);
      else n_pass++;
      req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_overflow();
      test_simultaneous_end();
      test_restart();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
